apu_irq_ctrl: RTL and testbench
===============================

// Module: apu_irq_ctrl
// PURPOSE
//  APU interrupt controller. Sits directly downstream of the APU timer and the other APU
//  peripherals. It aggregates their IRQ lines into one interrupt request plus a source
//  number for the APU processor. Each source can be level-sensitive (timer style) or
//  rising-edge latched, and has an enable mask and a software force bit.
//  Configuration is through a zero-wait-state AHB-Lite slave port on the APU bus.
// PARAMETERS
//  N_IRQ   8   number of interrupt sources, 1..16; source 0 has highest priority
//  W_NUM   4   width of irq_num; must satisfy 2**W_NUM >= N_IRQ
// PORTS
//  clk                input   1      system clock; the only clock
//  rst                input   1      reset, synchronous, active-high
//  ahbls_haddr        input   16     AHB-Lite address; bits [4:2] decoded, rest ignored
//  ahbls_htrans       input   2      AHB-Lite transfer type; bit 1 set = active transfer
//  ahbls_hwrite       input   1      AHB-Lite write
//  ahbls_hsize        input   3      AHB-Lite size; ignored, every access treated as 32-bit
//  ahbls_hready       input   1      AHB-Lite bus ready
//  ahbls_hready_resp  output  1      tied 1
//  ahbls_hwdata       input   32     AHB-Lite write data
//  ahbls_hrdata       output  32     AHB-Lite read data
//  ahbls_hresp        output  1      tied 0
//  irq_src            input   N_IRQ  raw source lines (e.g. apu_timer irq on bit 0)
//  irq                output  1      interrupt request to the APU processor
//  irq_num            output  W_NUM  lowest-numbered active source; 0 when irq=0
// BEHAVIOUR
//  Register map (offsets in bytes; unused high bits read 0; unmapped offsets read 0
//  and ignore writes; no bus errors):
//   0x00  ENABLE   RW   per-source enable mask
//   0x04  EDGE     RW   1 = rising-edge latched, 0 = level
//   0x08  PENDING  R/W1C  reads raw pending; W1C clears edge latches only
//   0x0C  FORCE    RW   software-asserted pending bits
//   0x10  ACTIVE   RO   {irq, 27'b0, irq_num} (irq in bit 31, irq_num in bits [W_NUM-1:0])
//  - Address phase is captured when hready & htrans[1]. The write takes effect at the
//    clock edge ending the data phase, using hwdata, so a readback in the next transfer
//    shows the new value. Read data is driven combinationally in the data phase.
//  - Edge detect: src_q <= irq_src every cycle. A rise (irq_src & ~src_q) on a source with
//    EDGE=1 sets latch[i]. If a set and a W1C hit the same cycle, set wins.
//  - Clearing EDGE[i] clears latch[i] on the same edge.
//  - Pending p[i] = (EDGE[i] ? latch[i] : irq_src[i]) | FORCE[i]. Active a = p & ENABLE.
//  - Outputs are registered: irq <= |a; irq_num <= index of the lowest set bit of a.
//    Latency is 1 cycle from irq_src to irq for level sources and 2 cycles for edge sources.
//  - Level sources have no latch: if a source drops, irq drops 1 cycle later.
//    A level source cannot be cleared through PENDING.
//  - Reset: all registers, latches, src_q, irq and irq_num are 0. A source held high
//    through reset does not count as an edge.
//  - Masking: a source latched while ENABLE=0 stays pending and asserts irq as soon as
//    it is enabled.
//  - Multiple active sources: irq_num shows the lowest index. Once that source is
//    cleared, irq_num moves to the next active source on the following cycle, and
//    irq stays high throughout.
// STRUCTURE
//  - Shared include apu_irq_ctrl_regs.vh holds the register offset localparams
//    (IRQ_ENABLE, IRQ_EDGE, IRQ_PENDING, IRQ_FORCE, IRQ_ACTIVE). The APU firmware
//    header is generated from it.
//  - One sub-module, apu_irq_prio: a combinational lowest-set-bit encoder of width N_IRQ,
//    producing {valid, num}.
//  - Bus decode, registers and edge latches sit in the top level.
// TESTING
//  1 Reset: hold rst 3 cycles with irq_src=8'hFF -> every register reads 0; irq=0,
//    irq_num=0; after release no latch is set.
//  2 Level: ENABLE=8'h01, EDGE=0, irq_src[0] high for 1 cycle -> irq high for exactly
//    1 cycle, starting 1 cycle later; irq_num=0.
//  3 Edge: EDGE=ENABLE=8'h04, pulse irq_src[2] -> irq=1, irq_num=2, held after the pulse
//    ends; write PENDING=8'h04 -> irq=0 one cycle after the write data phase.
//  4 Set vs clear: in the W1C data-phase cycle, give irq_src[2] a rising edge ->
//    PENDING[2] stays 1 and irq stays 1.
//  5 Priority: latch sources 5 and 3, ENABLE=8'hFF -> irq_num=3; clear 3 -> irq_num=5
//    next cycle with no irq gap; read ACTIVE=32'h8000_0005.
//  6 Mask and force: a source latched with ENABLE=0 gives irq=0; set ENABLE -> irq=1.
//    FORCE=8'h80 with ENABLE[7]=1 -> irq=1, irq_num=7; clear FORCE -> irq=0.

Source files
------------

// File: rtl/apu_irq_ctrl_pkg.sv
// apu_irq_ctrl_pkg: register offsets and word-select codes for the APU interrupt controller
package apu_irq_ctrl_pkg;
    `include "apu_irq_ctrl_regs.vh"
    typedef enum logic [2:0] {
        SEL_ENABLE  = IRQ_ENABLE[4:2],
        SEL_EDGE    = IRQ_EDGE[4:2],
        SEL_PENDING = IRQ_PENDING[4:2],
        SEL_FORCE   = IRQ_FORCE[4:2],
        SEL_ACTIVE  = IRQ_ACTIVE[4:2]
    } reg_sel_e;
endpackage

// File: rtl/apu_irq_ctrl_regs.vh
// apu_irq_ctrl_regs: register byte offsets, shared with the APU firmware header
`ifndef APU_IRQ_CTRL_REGS_VH
`define APU_IRQ_CTRL_REGS_VH
localparam logic [4:0] IRQ_ENABLE  = 5'h00;
localparam logic [4:0] IRQ_EDGE    = 5'h04;
localparam logic [4:0] IRQ_PENDING = 5'h08;
localparam logic [4:0] IRQ_FORCE   = 5'h0C;
localparam logic [4:0] IRQ_ACTIVE  = 5'h10;
`endif

// File: rtl/apu_irq_prio.sv
// apu_irq_prio: lowest-set-bit encoder, bit 0 has highest priority
module apu_irq_prio #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] num
);
    always_comb begin
        valid = |req;
        num = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) num = W'(i);
    end
endmodule

// File: rtl/apu_irq_ctrl.sv
// apu_irq_ctrl: aggregates APU peripheral IRQ lines into one request plus source number
module apu_irq_ctrl
    import apu_irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int W_NUM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ahbls_haddr,
    input  logic [1:0]       ahbls_htrans,
    input  logic             ahbls_hwrite,
    input  logic [2:0]       ahbls_hsize,
    input  logic             ahbls_hready,
    output logic             ahbls_hready_resp,
    input  logic [31:0]      ahbls_hwdata,
    output logic [31:0]      ahbls_hrdata,
    output logic             ahbls_hresp,
    input  logic [N_IRQ-1:0] irq_src,
    output logic             irq,
    output logic [W_NUM-1:0] irq_num
);
    logic             dph_vld, dph_wr, wr, prio_vld, unused_ok;
    logic [2:0]       dph_sel;
    logic [N_IRQ-1:0] enable, edge_en, frc, latch, src_q, wdat, w1c, edge_nxt, pend, act;
    logic [W_NUM-1:0] prio_num;
    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp = 1'b0;
    assign unused_ok = ^{ahbls_hsize, ahbls_haddr[15:5], ahbls_haddr[1:0], ahbls_htrans[0],
                         ahbls_hwdata[31:N_IRQ]};
    assign wr = dph_vld & dph_wr & ahbls_hready;
    assign wdat = ahbls_hwdata[N_IRQ-1:0];
    assign w1c = (wr && dph_sel == SEL_PENDING) ? wdat : '0;
    assign edge_nxt = (wr && dph_sel == SEL_EDGE) ? wdat : edge_en;
    assign pend = (edge_en & latch) | (~edge_en & irq_src) | frc;
    assign act = pend & enable;
    assign ahbls_hrdata = !dph_vld                ? 32'h0 :
                          dph_sel == SEL_ENABLE  ? 32'(enable) :
                          dph_sel == SEL_EDGE    ? 32'(edge_en) :
                          dph_sel == SEL_PENDING ? 32'(pend) :
                          dph_sel == SEL_FORCE   ? 32'(frc) :
                          dph_sel == SEL_ACTIVE  ? {irq, {(31-W_NUM){1'b0}}, irq_num} : 32'h0;
    apu_irq_prio #(.N(N_IRQ), .W(W_NUM)) u_prio (.req(act), .valid(prio_vld), .num(prio_num));
    always_ff @(posedge clk) begin
        if (rst) begin
            dph_vld <= 1'b0;
            dph_wr <= 1'b0;
            dph_sel <= '0;
            enable <= '0;
            edge_en <= '0;
            frc <= '0;
            latch <= '0;
            src_q <= '0;
            irq <= 1'b0;
            irq_num <= '0;
        end else begin
            if (ahbls_hready) begin
                dph_vld <= ahbls_htrans[1];
                dph_wr <= ahbls_hwrite;
                dph_sel <= ahbls_haddr[4:2];
            end
            if (wr && dph_sel == SEL_ENABLE) enable <= wdat;
            if (wr && dph_sel == SEL_FORCE) frc <= wdat;
            edge_en <= edge_nxt;
            // a new rise beats a simultaneous W1C; dropping EDGE discards the latch
            latch <= edge_nxt & ((latch & ~w1c) | (irq_src & ~src_q & edge_en));
            src_q <= irq_src;
            irq <= prio_vld;
            irq_num <= prio_num;
        end
    end
endmodule

// File: tb/tb_apu_irq_ctrl.sv
// tb_apu_irq_ctrl: directed bench with a read-data scoreboard for apu_irq_ctrl
module tb_apu_irq_ctrl;
    import apu_irq_ctrl_pkg::*;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0, hready = 1'b1, hready_resp, hresp, irq;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = '0, hrdata;
    logic [7:0]  irq_src = '0;
    logic [3:0]  irq_num;
    logic [31:0] rd_q[$];
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    apu_irq_ctrl #(.N_IRQ(8), .W_NUM(4)) dut (
        .clk(clk), .rst(rst), .ahbls_haddr(haddr), .ahbls_htrans(htrans),
        .ahbls_hwrite(hwrite), .ahbls_hsize(hsize), .ahbls_hready(hready),
        .ahbls_hready_resp(hready_resp), .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata),
        .ahbls_hresp(hresp), .irq_src(irq_src), .irq(irq), .irq_num(irq_num)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_irq(input string tag, input logic e_irq, input logic [3:0] e_num);
        chk({tag, "_irq"}, 32'(irq), 32'(e_irq));
        chk({tag, "_num"}, 32'(irq_num), 32'(e_num));
    endtask
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        haddr = a; htrans = 2'b10; hwrite = 1'b1;
        tick();
        hwdata = d; htrans = 2'b00; hwrite = 1'b0;
        tick();
    endtask
    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] e);
        logic [31:0] exp;
        rd_q.push_back(e);
        haddr = a; htrans = 2'b10; hwrite = 1'b0;
        tick();
        htrans = 2'b00;
        if (rd_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else begin
            exp = rd_q.pop_front();
            chk(tag, hrdata, exp);
        end
        tick();
    endtask
    initial begin
        // reset with every source high
        irq_src = 8'hFF;
        repeat (3) tick();
        chk_irq("rst", 1'b0, 4'd0);
        rst = 1'b0;
        tick(); tick();
        chk_irq("rst_rel", 1'b0, 4'd0);
        irq_src = 8'h00;
        tick();
        rd("rst_enable", 16'(IRQ_ENABLE), 32'h0);
        rd("rst_edge", 16'(IRQ_EDGE), 32'h0);
        rd("rst_pending", 16'(IRQ_PENDING), 32'h0);
        rd("rst_force", 16'(IRQ_FORCE), 32'h0);
        rd("rst_active", 16'(IRQ_ACTIVE), 32'h0);
        wr(16'(IRQ_EDGE), 32'hFF);
        rd("rst_nolatch", 16'(IRQ_PENDING), 32'h0);
        wr(16'(IRQ_EDGE), 32'h00);
        // level source
        wr(16'(IRQ_ENABLE), 32'h01);
        irq_src = 8'h01;
        chk_irq("lvl_pre", 1'b0, 4'd0);
        tick();
        chk_irq("lvl_on", 1'b1, 4'd0);
        irq_src = 8'h00;
        tick();
        chk_irq("lvl_off", 1'b0, 4'd0);
        // edge source, latch and W1C
        wr(16'(IRQ_EDGE), 32'h04);
        wr(16'(IRQ_ENABLE), 32'h04);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        chk_irq("edge_lat1", 1'b0, 4'd0);
        tick();
        chk_irq("edge_on", 1'b1, 4'd2);
        tick();
        chk_irq("edge_held", 1'b1, 4'd2);
        rd("edge_pend", 16'(IRQ_PENDING), 32'h04);
        wr(16'(IRQ_PENDING), 32'h04);
        chk_irq("w1c_edge", 1'b1, 4'd2);
        tick();
        chk_irq("w1c_after", 1'b0, 4'd0);
        // set beats clear in the same cycle
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        chk_irq("svc_pre", 1'b1, 4'd2);
        haddr = 16'(IRQ_PENDING); htrans = 2'b10; hwrite = 1'b1;
        tick();
        hwdata = 32'h04; htrans = 2'b00; hwrite = 1'b0; irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        chk_irq("svc_irq", 1'b1, 4'd2);
        rd("svc_pend", 16'(IRQ_PENDING), 32'h04);
        wr(16'(IRQ_PENDING), 32'h04);
        tick();
        chk_irq("svc_clr", 1'b0, 4'd0);
        // priority between two latched sources
        wr(16'(IRQ_EDGE), 32'hFF);
        wr(16'(IRQ_ENABLE), 32'hFF);
        irq_src = 8'h28;
        tick();
        irq_src = 8'h00;
        tick();
        chk_irq("prio_3", 1'b1, 4'd3);
        wr(16'(IRQ_PENDING), 32'h08);
        chk_irq("prio_clr3", 1'b1, 4'd3);
        tick();
        chk_irq("prio_5", 1'b1, 4'd5);
        rd("prio_active", 16'(IRQ_ACTIVE), 32'h8000_0005);
        wr(16'(IRQ_PENDING), 32'h20);
        tick();
        chk_irq("prio_none", 1'b0, 4'd0);
        // masked latch, then force
        wr(16'(IRQ_ENABLE), 32'h00);
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick(); tick();
        chk_irq("mask_off", 1'b0, 4'd0);
        rd("mask_pend", 16'(IRQ_PENDING), 32'h02);
        wr(16'(IRQ_ENABLE), 32'h02);
        tick();
        chk_irq("mask_en", 1'b1, 4'd1);
        wr(16'(IRQ_PENDING), 32'h02);
        tick();
        chk_irq("mask_clr", 1'b0, 4'd0);
        wr(16'(IRQ_ENABLE), 32'h80);
        wr(16'(IRQ_FORCE), 32'h80);
        tick();
        chk_irq("force_on", 1'b1, 4'd7);
        rd("force_rd", 16'(IRQ_FORCE), 32'h80);
        wr(16'(IRQ_FORCE), 32'h00);
        tick();
        chk_irq("force_off", 1'b0, 4'd0);
        // address aliasing and unmapped offsets
        rd("alias_edge", 16'hFF04, 32'hFF);
        wr(16'h0018, 32'hFFFF_FFFF);
        rd("unmapped", 16'h001C, 32'h0);
        rd("enable_keep", 16'(IRQ_ENABLE), 32'h80);
        chk("hresp", {30'd0, hresp, hready_resp}, 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
